// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for serial_add_ctrl.
// master drives requests and operands; slave is the serial adder.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full_adder produces one result bit per clock, LSB first,
// sequenced by an IDLE/RUN/DONE controller with a synchronous active-low reset.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_cout;

  full_adder u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // sum register is deliberately left alone at acceptance so the previous
  // result stays visible until the first RUN edge overwrites its MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          // shift-in at the MSB written as shift/OR so WIDTH=1 needs no special case
          sum_sr <= (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
          carry  <= fa_cout;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_sr;
  assign bus.cout  = carry;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1: directed table,
// random operands against an arithmetic model, and multi-cycle corner sequences.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl_if #(.WIDTH(8)) if8 ();
  serial_add_ctrl_if #(.WIDTH(1)) if1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One complete operation on the 8-bit instance; operands are scrambled right after acceptance.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                     output logic [7:0] s, output logic c, output int nbusy,
                     output logic d, output logic rdy_after);
    @(negedge clk);
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = ci;
    @(negedge clk);
    if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
    nbusy = 0;
    while (if8.busy && nbusy < 40) begin
      nbusy++;
      @(negedge clk);
    end
    d = if8.done; s = if8.sum; c = if8.cout;
    @(negedge clk);
    rdy_after = if8.ready & ~if8.done;
  endtask

  task automatic op1(input logic a, input logic b, input logic ci,
                     output logic s, output logic c, output int nbusy, output logic d);
    @(negedge clk);
    if1.start = 1'b1; if1.a = a; if1.b = b; if1.cin = ci;
    @(negedge clk);
    if1.start = 1'b0; if1.a = ~a; if1.b = ~b; if1.cin = ~ci;
    nbusy = 0;
    while (if1.busy && nbusy < 10) begin
      nbusy++;
      @(negedge clk);
    end
    d = if1.done; s = if1.sum; c = if1.cout;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [7:0] s8, ra, rb;
  logic       c8, d8, rdy8, rc, s1, c1, d1, seen_done;
  int         nb, t1, t2, ndone;
  logic [7:0] sums[2];
  logic [8:0] model;

  initial begin
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if1.start = 1'b1; if1.a = '1; if1.b = '1; if1.cin = 1'b1;
    tbl[0] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    tbl[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    // reset held for two edges, with start asserted on the 1-bit instance
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready8", 32'(if8.ready), 32'd1);
    check("rst_busy8",  32'(if8.busy),  32'd0);
    check("rst_done8",  32'(if8.done),  32'd0);
    check("rst_sum8",   32'(if8.sum),   32'h00);
    check("rst_cout8",  32'(if8.cout),  32'd0);
    check("rst_busy1",  32'(if1.busy),  32'd0);
    if1.start = 1'b0;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].cin, s8, c8, nb, d8, rdy8);
      check("tbl_busy_cycles", 32'(nb),   32'd8);
      check("tbl_done",        32'(d8),   32'd1);
      check("tbl_sum",         32'(s8),   32'(tbl[i].s));
      check("tbl_cout",        32'(c8),   32'(tbl[i].c));
      check("tbl_ready_after", 32'(rdy8), 32'd1);
    end

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      model = 9'(ra) + 9'(rb) + 9'(rc);
      op8(ra, rb, rc, s8, c8, nb, d8, rdy8);
      check("rnd_done", 32'(d8), 32'd1);
      check("rnd_sum",  32'(s8), 32'(model[7:0]));
      check("rnd_cout", 32'(c8), 32'(model[8]));
    end

    // WIDTH=1: full-adder truth table, done one cycle after a single busy cycle
    for (int i = 0; i < 8; i++) begin
      int t;
      t = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
      op1(1'((i >> 2) & 1), 1'((i >> 1) & 1), 1'(i & 1), s1, c1, nb, d1);
      check("w1_busy_cycles", 32'(nb), 32'd1);
      check("w1_done",        32'(d1), 32'd1);
      check("w1_sum",         32'(s1), 32'(t % 2));
      check("w1_cout",        32'(c1), 32'(t / 2));
    end

    // start pulsed during RUN with different operands is ignored
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0;
    @(negedge clk); if8.start = 1'b0;
    @(negedge clk);
    @(negedge clk); if8.start = 1'b1; if8.a = 8'hF0; if8.b = 8'h0F; if8.cin = 1'b1;
    @(negedge clk); if8.start = 1'b0;
    nb = 0;
    while (!if8.done && nb < 20) begin nb++; @(negedge clk); end
    check("ign_done", 32'(if8.done), 32'd1);
    check("ign_sum",  32'(if8.sum),  32'h46);
    check("ign_cout", 32'(if8.cout), 32'd0);
    repeat (2) @(negedge clk);
    check("ign_no_rerun", 32'(if8.busy), 32'd0);

    // continuous start: done every WIDTH+2 cycles, each op using its own operands
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'd3; if8.b = 8'd4; if8.cin = 1'b0;
    ndone = 0; t1 = 0; t2 = 0;
    for (int k = 0; k < 40 && ndone < 2; k++) begin
      @(negedge clk);
      if (k == 3) if8.a = 8'd10;
      if (if8.done) begin
        sums[ndone] = if8.sum;
        if (ndone == 0) t1 = cyc; else t2 = cyc;
        ndone++;
      end
    end
    if8.start = 1'b0;
    check("b2b_pulses",   32'(ndone),   32'd2);
    check("b2b_interval", 32'(t2 - t1), 32'd10);
    check("b2b_sum0",     32'(sums[0]), 32'd7);
    check("b2b_sum1",     32'(sums[1]), 32'd14);
    repeat (3) @(negedge clk);

    // reset at cycle 4 of RUN aborts without a done pulse
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h55; if8.b = 8'h22; if8.cin = 1'b0;
    @(negedge clk); if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready", 32'(if8.ready), 32'd1);
    check("abort_busy",  32'(if8.busy),  32'd0);
    check("abort_done",  32'(if8.done),  32'd0);
    check("abort_sum",   32'(if8.sum),   32'h00);
    check("abort_cout",  32'(if8.cout),  32'd0);
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    op8(8'h21, 8'h13, 1'b1, s8, c8, nb, d8, rdy8);
    check("post_abort_done", 32'(d8), 32'd1);
    check("post_abort_sum",  32'(s8), 32'h35);
    check("post_abort_cout", 32'(c8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
